// File: rtl/spi_result_bridge.sv
// spi_result_bridge: packs completed measurements into 32-bit frames, queues them in a
// small result FIFO for the SPI slave write port, and decodes SPI command words into a
// mode-select register and a FIFO clear request.
// Build option: define SPI_RESULT_WR_TIMEOUT_EN to re-pulse wren_o when the slave does
// not acknowledge a write within WR_TIMEOUT cycles.
module spi_result_bridge #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WR_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        done_i,
    input  logic [15:0] count_i,
    input  logic [2:0]  range_sel_i,
    input  logic        ref_sign_i,
    input  logic        range_error_i,
    input  logic        sat_hi_i,
    input  logic        sat_lo_i,
    input  logic        ref_ok_i,
    input  logic        di_req_i,
    input  logic        wr_ack_i,
    input  logic        do_valid_i,
    input  logic [31:0] do_i,
    output logic [31:0] di_o,
    output logic        wren_o,
    output logic        irq_o,
    output logic [1:0]  mode_sel_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [7:0] OP_MODE  = 8'hA5;
    localparam logic [7:0] OP_CLEAR = 8'h5A;

    // One queued result: sequence tag, state-machine/analog flags, counter value
    typedef struct packed {
        logic [2:0]  seq;
        logic [7:0]  flags;
        logic [15:0] count;
    } entry_t;

    typedef enum logic { ST_WRITE = 1'b0, ST_LOADED = 1'b1 } state_t;

    entry_t        r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_seq;
    logic          r_ovf;
    logic          r_irq;
    logic [1:0]    r_mode;
    logic          r_di_req_d;
    state_t        r_state;
    logic          r_wren;
    logic [31:0]   r_di;

    logic [7:0]    w_flags;
    logic          w_clear;
    logic          w_mode_cmd;
    logic          w_full;
    logic          w_empty;
    logic          w_rise;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_cnt_nxt;
    entry_t        w_head;
    logic [3:0]    w_lvl_raw;
    logic [2:0]    w_lvl;
    logic [31:0]   w_idle_frame;
    logic [31:0]   w_clear_frame;
    logic [31:0]   w_head_frame;
    logic          w_unused;

`ifdef SPI_RESULT_WR_TIMEOUT_EN
    localparam int unsigned TW = $clog2(WR_TIMEOUT + 1);
    logic [TW-1:0] r_to_cnt;
    assign w_unused = ^do_i[23:2];
`else
    assign w_unused = ^{do_i[23:2], 32'(WR_TIMEOUT)};
`endif

    assign w_flags    = {ref_sign_i, range_sel_i, range_error_i, sat_hi_i, sat_lo_i, ref_ok_i};
    assign w_clear    = do_valid_i && (do_i[31:24] == OP_CLEAR);
    assign w_mode_cmd = do_valid_i && (do_i[31:24] == OP_MODE);
    assign w_full     = (r_cnt == CW'(FIFO_DEPTH));
    assign w_empty    = (r_cnt == '0);
    assign w_rise     = di_req_i && !r_di_req_d;

    // A valid frame leaves the FIFO only when its write is acknowledged
    assign w_pop      = (r_state == ST_WRITE) && r_wren && wr_ack_i && r_di[31] && !w_clear;
    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign w_push     = done_i && !w_clear && (!w_full || w_pop);
    assign w_drop     = done_i && !w_clear && w_full && !w_pop;
    assign w_cnt_nxt  = w_clear ? '0 : (r_cnt + CW'(w_push) - CW'(w_pop));

    assign w_head     = r_mem[r_rptr];
    assign w_lvl_raw  = 4'(r_cnt) - 4'd1;
    assign w_lvl      = w_lvl_raw[3] ? 3'd7 : w_lvl_raw[2:0];

    assign w_idle_frame  = {4'b0, w_flags, r_ovf, 3'b0, 16'h0000};
    assign w_clear_frame = {4'b0, w_flags, 1'b0, 3'b0, 16'h0000};
    assign w_head_frame  = {1'b1, w_head.seq, w_head.flags, r_ovf, w_lvl, w_head.count};

    // Result storage; contents are only meaningful between the pointers
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_seq, w_flags, count_i};
        end
    end

    // FIFO pointers, level, sequence counter, sticky overflow and interrupt
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_seq  <= '0;
            r_ovf  <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_irq <= (w_cnt_nxt != '0);
            if (w_clear) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_seq  <= '0;
                r_ovf  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                    r_seq  <= r_seq + 3'd1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end else if (w_pop && r_di[19]) begin
                    r_ovf <= 1'b0;
                end
            end
        end
    end

    // Command register and data-request edge detector
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mode     <= 2'b00;
            r_di_req_d <= 1'b0;
        end else begin
            r_di_req_d <= di_req_i;
            if (w_mode_cmd) begin
                r_mode <= do_i[1:0];
            end
        end
    end

    // Slave write handshake: hold a frame in WRITE until acked, reload on data request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_WRITE;
            r_wren   <= 1'b1;
            r_di     <= '0;
`ifdef SPI_RESULT_WR_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
        end else begin
            case (r_state)
                ST_WRITE: begin
                    if (w_clear && r_di[31]) begin
                        // Queued result was flushed; offer an idle frame instead
                        r_di     <= w_clear_frame;
`ifdef SPI_RESULT_WR_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
`ifdef SPI_RESULT_WR_TIMEOUT_EN
                    else if (!r_wren) begin
                        r_wren   <= 1'b1;
                        r_to_cnt <= '0;
                    end
`endif
                    else if (wr_ack_i) begin
                        r_state <= ST_LOADED;
                        r_wren  <= 1'b0;
                    end
`ifdef SPI_RESULT_WR_TIMEOUT_EN
                    else if (r_to_cnt == TW'(WR_TIMEOUT - 1)) begin
                        r_wren   <= 1'b0;
                        r_to_cnt <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
`endif
                end
                ST_LOADED: begin
                    if (w_rise) begin
                        r_state <= ST_WRITE;
                        r_wren  <= 1'b1;
`ifdef SPI_RESULT_WR_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                        if (w_clear) begin
                            r_di <= w_clear_frame;
                        end else if (w_empty) begin
                            r_di <= w_idle_frame;
                        end else begin
                            r_di <= w_head_frame;
                        end
                    end
                end
            endcase
        end
    end

    assign di_o       = r_di;
    assign wren_o     = r_wren;
    assign irq_o      = r_irq;
    assign mode_sel_o = r_mode;

endmodule
